// File: rtl/celda_tipica_der_izq_if.sv
// Serial comparison bus for celda_tipica_der_izq.
// CELDA_EQ_FLAG_EN adds the a_eq_b result line.
interface celda_tipica_der_izq_if #(
    parameter int WIDTH = 8,
    parameter int CNT_W = $clog2(WIDTH + 1)
);
    logic             start;
    logic             bit_valid;
    logic             ser_a;
    logic             ser_b;
    logic             state_q;
    logic [CNT_W-1:0] bit_cnt;
    logic             done;
    logic             a_ge_b;
`ifdef CELDA_EQ_FLAG_EN
    logic             a_eq_b;

    modport master (output start, bit_valid, ser_a, ser_b,
                    input  state_q, bit_cnt, done, a_ge_b, a_eq_b);
    modport slave  (input  start, bit_valid, ser_a, ser_b,
                    output state_q, bit_cnt, done, a_ge_b, a_eq_b);
`else
    modport master (output start, bit_valid, ser_a, ser_b,
                    input  state_q, bit_cnt, done, a_ge_b);
    modport slave  (input  start, bit_valid, ser_a, ser_b,
                    output state_q, bit_cnt, done, a_ge_b);
`endif
endinterface

// File: rtl/celda_tipica_der_izq.sv
// LSB-first iterative comparator cell plus a serial engine reporting A >= B.
// Optional equality flag: define CELDA_EQ_FLAG_EN.
module celda_tipica_der_izq #(
    parameter int WIDTH = 8,
    parameter int CNT_W = $clog2(WIDTH + 1)
) (
    input  logic clk,
    input  logic rst_n,
    input  logic p,
    input  logic Ai,
    input  logic Bi,
    output logic P,
    celda_tipica_der_izq_if.slave sif
);
    typedef enum logic {ST_B = 1'b0, ST_A = 1'b1} st_e;

    // Differing bits override the running state; equal bits keep it.
    function automatic logic cell_f(input logic ps, input logic ai, input logic bi);
        return (ai & ~bi) | (~(ai ^ bi) & ps);
    endfunction

    assign P = cell_f(p, Ai, Bi);

    st_e              st_q, st_d, st_base;
    logic [CNT_W-1:0] cnt_q, cnt_d, cnt_base;
    logic             done_q, done_d;
    logic             ge_q, ge_d;
    logic             take, last, nxt_bit;
`ifdef CELDA_EQ_FLAG_EN
    logic             eq_q, eq_d, eq_base;
    logic             aeq_q, aeq_d;
`endif

    always_comb begin
        // start restarts from state a with an empty count, so a bit in the same cycle builds on that
        st_base  = sif.start ? ST_A : st_q;
        cnt_base = sif.start ? '0 : cnt_q;
        take     = sif.bit_valid && (sif.start || !done_q);
        nxt_bit  = cell_f(st_base, sif.ser_a, sif.ser_b);
        last     = take && (cnt_base == CNT_W'(WIDTH - 1));

        st_d   = st_base;
        cnt_d  = cnt_base;
        done_d = sif.start ? 1'b0 : done_q;
        ge_d   = sif.start ? 1'b0 : ge_q;
        if (take) begin
            st_d  = st_e'(nxt_bit);
            cnt_d = cnt_base + CNT_W'(1);
        end
        if (last) begin
            done_d = 1'b1;
            ge_d   = nxt_bit;
        end
`ifdef CELDA_EQ_FLAG_EN
        eq_base = sif.start ? 1'b1 : eq_q;
        eq_d    = eq_base;
        aeq_d   = sif.start ? 1'b0 : aeq_q;
        if (take && (sif.ser_a != sif.ser_b))
            eq_d = 1'b0;
        if (last)
            aeq_d = eq_d;
`endif
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            st_q   <= ST_A;
            cnt_q  <= '0;
            done_q <= 1'b0;
            ge_q   <= 1'b0;
        end else begin
            st_q   <= st_d;
            cnt_q  <= cnt_d;
            done_q <= done_d;
            ge_q   <= ge_d;
        end
    end

`ifdef CELDA_EQ_FLAG_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            eq_q  <= 1'b1;
            aeq_q <= 1'b0;
        end else begin
            eq_q  <= eq_d;
            aeq_q <= aeq_d;
        end
    end

    assign sif.a_eq_b = aeq_q;
`endif

    assign sif.state_q = st_q;
    assign sif.bit_cnt = cnt_q;
    assign sif.done    = done_q;
    assign sif.a_ge_b  = ge_q;
endmodule

// File: tb/tb_celda_tipica_der_izq.sv
// Scoreboard bench: results are predicted from unsigned word compares.
module tb_celda_tipica_der_izq;
    localparam int WIDTH = 8;
    localparam int CNT_W = $clog2(WIDTH + 1);

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic p = 1'b0, Ai = 1'b0, Bi = 1'b0;
    logic P;

    celda_tipica_der_izq_if #(.WIDTH(WIDTH), .CNT_W(CNT_W)) sif ();

    celda_tipica_der_izq #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .p     (p),
        .Ai    (Ai),
        .Bi    (Bi),
        .P     (P),
        .sif   (sif)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic ge;
        logic eq;
    } exp_t;
    exp_t sb[$];

    int n_vec = 0;
    int n_err = 0;
    logic done_d = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference: state after k LSB-first bits is (A mod 2^k) >= (B mod 2^k).
    function automatic logic ref_ge(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b, input int k);
        longint unsigned m, am, bm;
        m  = (64'd1 << k) - 64'd1;
        am = longint'(a) & m;
        bm = longint'(b) & m;
        return am >= bm;
    endfunction

    // Drive one cycle of inputs, wait for the consuming edge, settle.
    task automatic cyc(input logic st, input logic bv, input logic a, input logic b);
        sif.start     = st;
        sif.bit_valid = bv;
        sif.ser_a     = a;
        sif.ser_b     = b;
        @(posedge clk);
        #1;
    endtask

    task automatic send_word(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                             input bit merge_start, input bit gaps);
        int first;
        exp_t e;
        e.ge = (a >= b);
        e.eq = (a == b);
        sb.push_back(e);
        if (merge_start) begin
            cyc(1'b1, 1'b1, a[0], b[0]);
            first = 1;
        end else begin
            cyc(1'b1, 1'b0, 1'b0, 1'b0);
            first = 0;
        end
        for (int i = first; i < WIDTH; i++) begin
            if (gaps && $urandom_range(0, 3) == 0)
                repeat ($urandom_range(1, 2)) cyc(1'b0, 1'b0, 1'($urandom), 1'($urandom));
            cyc(1'b0, 1'b1, a[i], b[i]);
        end
        cyc(1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    // Monitor: every rising done retires one scoreboard entry.
    always @(negedge clk) begin
        if (sif.done && !done_d) begin
            if (sb.size() == 0) begin
                n_vec++;
                n_err++;
                $display("FAIL unexpected_done: got done=1 expected no pending word at %0t", $time);
            end else begin
                exp_t e;
                e = sb.pop_front();
                chk("a_ge_b", 32'(sif.a_ge_b), 32'(e.ge));
                chk("final_state", 32'(sif.state_q), 32'(e.ge));
                chk("final_cnt", 32'(sif.bit_cnt), WIDTH);
`ifdef CELDA_EQ_FLAG_EN
                chk("a_eq_b", 32'(sif.a_eq_b), 32'(e.eq));
`endif
            end
        end
        done_d <= sif.done;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [3:0] exp_p1, exp_p0;
        logic [WIDTH-1:0] ga, gb;
        logic ge_ref;

        sif.start = 1'b0;
        sif.bit_valid = 1'b0;
        sif.ser_a = 1'b0;
        sif.ser_b = 1'b0;

        // Cell truth table, entries in AiBi order 00,01,10,11.
        exp_p1 = 4'b1101;
        exp_p0 = 4'b0100;
        for (int pv = 1; pv >= 0; pv--) begin
            for (int ab = 0; ab < 4; ab++) begin
                p  = 1'(pv);
                Ai = 1'(ab >> 1);
                Bi = 1'(ab);
                #10;
                chk("cell_P", 32'(P), 32'(pv ? exp_p1[ab] : exp_p0[ab]));
                #10;
            end
        end

        chk("rst_state", 32'(sif.state_q), 32'd1);
        chk("rst_cnt", 32'(sif.bit_cnt), 32'd0);
        chk("rst_done", 32'(sif.done), 32'd0);
        chk("rst_ge", 32'(sif.a_ge_b), 32'd0);
`ifdef CELDA_EQ_FLAG_EN
        chk("rst_eq", 32'(sif.a_eq_b), 32'd0);
`endif
        @(posedge clk);
        #1 rst_n = 1'b1;

        send_word(8'h5A, 8'h3C, 1'b0, 1'b0);
        send_word(8'h3C, 8'h5A, 1'b0, 1'b0);
        send_word(8'hA5, 8'hA5, 1'b0, 1'b0);
        send_word(8'h01, 8'h80, 1'b0, 1'b0);
        send_word(8'h80, 8'h7F, 1'b1, 1'b0);

        // Gap mid-word: state and count hold while bit_valid is low.
        ga = 8'h16;
        gb = 8'h0B;
        begin
            exp_t e;
            e.ge = (ga >= gb);
            e.eq = (ga == gb);
            sb.push_back(e);
        end
        cyc(1'b1, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) cyc(1'b0, 1'b1, ga[i], gb[i]);
        ge_ref = ref_ge(ga, gb, 3);
        chk("gap_state_pre", 32'(sif.state_q), 32'(ge_ref));
        chk("gap_cnt_pre", 32'(sif.bit_cnt), 32'd3);
        for (int k = 0; k < 3; k++) begin
            cyc(1'b0, 1'b0, 1'($urandom), 1'($urandom));
            chk("gap_state_hold", 32'(sif.state_q), 32'(ge_ref));
            chk("gap_cnt_hold", 32'(sif.bit_cnt), 32'd3);
        end
        for (int i = 3; i < WIDTH; i++) cyc(1'b0, 1'b1, ga[i], gb[i]);
        cyc(1'b0, 1'b0, 1'b0, 1'b0);

        // Extra bits after done are ignored.
        for (int k = 0; k < 3; k++) begin
            cyc(1'b0, 1'b1, 1'($urandom), 1'($urandom));
            chk("post_done", 32'(sif.done), 32'd1);
            chk("post_cnt", 32'(sif.bit_cnt), WIDTH);
            chk("post_ge", 32'(sif.a_ge_b), 32'(ga >= gb));
            chk("post_state", 32'(sif.state_q), 32'(ga >= gb));
        end

        // Asynchronous reset mid-word, checked before any clock edge.
        ga = 8'h00;
        gb = 8'h0F;
        cyc(1'b1, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 4; i++) cyc(1'b0, 1'b1, ga[i], gb[i]);
        chk("pre_rst_state", 32'(sif.state_q), 32'(ref_ge(ga, gb, 4)));
        chk("pre_rst_cnt", 32'(sif.bit_cnt), 32'd4);
        cyc(1'b0, 1'b0, 1'b0, 1'b0);
        #2 rst_n = 1'b0;
        #1;
        chk("async_rst_state", 32'(sif.state_q), 32'd1);
        chk("async_rst_cnt", 32'(sif.bit_cnt), 32'd0);
        chk("async_rst_done", 32'(sif.done), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        send_word(8'hC3, 8'hC4, 1'b0, 1'b0);

        for (int n = 0; n < 40; n++) begin
            ga = WIDTH'($urandom);
            gb = ($urandom_range(0, 3) == 0) ? ga : WIDTH'($urandom);
            send_word(ga, gb, 1'($urandom), 1'b1);
        end

        repeat (3) cyc(1'b0, 1'b0, 1'b0, 1'b0);
        chk("sb_empty", 32'(sb.size()), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule

// File: doc/celda_tipica_der_izq.md
Name: celda_tipica_der_izq

Overview:
Typical cell of the right-to-left (LSB-first) iterative comparator network for words A and B. It has two parts:
- A purely combinational cell: present state p plus bits Ai, Bi give next state P.
- A clocked serial engine: one instance of the cell plus a state register, which compares two WIDTH-bit words fed one bit pair per cycle and reports A >= B.

State encoding: a = 1 ("A >= B so far"), b = 0 ("A < B so far").

Parameters:
- WIDTH, 8, number of bit pairs in one serial comparison (>= 1).
- CNT_W, $clog2(WIDTH+1), width of the bit counter.

Ports:
- clk, input, 1, system clock, rising edge.
- rst_n, input, 1, asynchronous active-low reset.
- p, input, 1, present state for the combinational cell.
- Ai, input, 1, bit i of A for the combinational cell.
- Bi, input, 1, bit i of B for the combinational cell.
- P, output, 1, combinational next state of the cell.
- start, input, 1, begin a new serial comparison.
- bit_valid, input, 1, ser_a/ser_b hold a valid bit pair this cycle.
- ser_a, input, 1, serial A bit, LSB first.
- ser_b, input, 1, serial B bit, LSB first.
- state_q, output, 1, registered iteration state.
- bit_cnt, output, CNT_W, bits consumed in the current comparison.
- done, output, 1, WIDTH bits consumed; result valid.
- a_ge_b, output, 1, final result: 1 when A >= B (unsigned).

Behaviour:
Combinational cell, zero latency, no clock involvement:
- P = (Ai & ~Bi) | (~(Ai ^ Bi) & p).
- Truth table, p=1 (state a): AiBi 00->1, 01->0, 10->1, 11->1.
- Truth table, p=0 (state b): AiBi 00->0, 01->0, 10->1, 11->0.
- Equal bits keep the state; differing bits override it (higher-order bits dominate because processing is LSB first).

Serial engine:
- The engine reuses the same cell function internally.
- Reset (rst_n=0, asynchronous): state_q=1, bit_cnt=0, done=0, a_ge_b=0.
- start=1 at a clock edge: state_q<=1 (state a, so equal words give A >= B), bit_cnt<=0, done<=0, a_ge_b<=0.
- start=1 with bit_valid=1 in the same cycle: the start value 1 is the present state, so state_q<=f(1,ser_a,ser_b) and bit_cnt<=1.
- bit_valid=1, done=0, start=0: state_q<=f(state_q,ser_a,ser_b) and bit_cnt<=bit_cnt+1.
- On the edge that consumes bit WIDTH: done<=1 and a_ge_b<=f(state_q,ser_a,ser_b), i.e. the final state. Both are visible the cycle after the last bit.
- While done=1: bit_valid is ignored and all registers hold until start or reset.
- bit_valid=0: registers hold.
- Reset asserted mid-comparison: immediate return to reset values; the partial result is discarded.
- No wrap-around: bit_cnt saturates at WIDTH.

Optional Feature:
- Macro: CELDA_EQ_FLAG_EN.
- When defined: adds output a_eq_b (1 bit) and an internal eq register.
  - eq is set to 1 on start and on reset.
  - eq is cleared on any consumed bit pair with ser_a != ser_b.
  - a_eq_b <= final eq, on the same edge that sets done; it holds 0 at reset.
- When undefined: the port and logic are absent; all other behaviour is identical.

Test Plan:
- Cell exhaustive: p=1 with AiBi=00,01,10,11, then p=0 with the same sequence, 20 ns each -> P = 1,0,1,1 then 0,0,1,0.
- Serial, WIDTH=8: A=0x5A, B=0x3C, LSB first -> done after 8 bits, a_ge_b=1, bit_cnt=8.
- Serial, WIDTH=8: A=0x3C, B=0x5A -> a_ge_b=0. Also A=B=0xA5 -> a_ge_b=1 (and a_eq_b=1 with CELDA_EQ_FLAG_EN).
- Serial: A=0x01, B=0x80 (LSB favours A, MSB favours B) -> a_ge_b=0, showing MSB dominance.
- Gaps and extras: bit_valid low for 3 cycles mid-word -> state_q and bit_cnt hold. Extra bit_valid after done -> no change.
- Reset: drop rst_n after 4 bits -> state_q=1, bit_cnt=0, done=0 immediately, without waiting for a clock edge. Then start plus a full word -> correct result.
